uart_cmd_wrapper: RTL and testbench

- Host-side link stage directly upstream of the command/config block.
- Assembles two received UART bytes (high byte first) into a 16-bit command and presents it with cmd_rdy, held until clr_cmd_rdy.
- Serializes the 8-bit response/dump bytes back to the host over an integrated 8N1 UART transmitter, reporting completion with resp_sent.
- Sits between the UART receiver (byte-level rx_rdy/rx_data interface) and the command/config block.

---
 rtl/uart_cmd_wrapper.sv | 162 ++++++++++++++++
 tb/tb_uart_cmd_wrapper.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_wrapper.sv
// Host link stage: pairs two received UART bytes into a 16-bit command and
// serializes response bytes back to the host as 8N1 frames.
`timescale 1ns/1ps

module uart_cmd_wrapper #(
   parameter int BAUD_DIV = 1736,
   parameter int TIMEOUT  = 1000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_rdy,
   output logic        clr_rx_rdy,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic [7:0]  resp,
   input  logic        send_resp,
   output logic        resp_sent,
   output logic        tx_busy,
   output logic        TX
);

   localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {WAIT_HI, WAIT_LO, HOLD} rx_state_t;
   typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

   rx_state_t       rx_state, rx_state_nxt;
   logic [15:0]     cmd_nxt;
   logic            cmd_rdy_nxt;
   logic            clr_rx_rdy_nxt;
   logic [TW-1:0]   to_cnt, to_cnt_nxt;
   logic            accept;

   tx_state_t       tx_state, tx_state_nxt;
   logic [9:0]      frame, frame_nxt;
   logic [BW-1:0]   baud_cnt, baud_cnt_nxt;
   logic [3:0]      bit_cnt, bit_cnt_nxt;
   logic            tx_busy_nxt;
   logic            resp_sent_nxt;

   // The clear pulse is still in flight while rx_rdy is high, so block a second capture.
   assign accept = rx_rdy & ~clr_rx_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state   <= WAIT_HI;
         cmd        <= '0;
         cmd_rdy    <= 1'b0;
         clr_rx_rdy <= 1'b0;
         to_cnt     <= '0;
      end else begin
         rx_state   <= rx_state_nxt;
         cmd        <= cmd_nxt;
         cmd_rdy    <= cmd_rdy_nxt;
         clr_rx_rdy <= clr_rx_rdy_nxt;
         to_cnt     <= to_cnt_nxt;
      end
   end

   always_comb begin
      rx_state_nxt   = rx_state;
      cmd_nxt        = cmd;
      cmd_rdy_nxt    = cmd_rdy;
      clr_rx_rdy_nxt = 1'b0;
      to_cnt_nxt     = to_cnt;
      case (rx_state)
         WAIT_HI: begin
            if (accept) begin
               cmd_nxt[15:8]  = rx_data;
               clr_rx_rdy_nxt = 1'b1;
               to_cnt_nxt     = '0;
               rx_state_nxt   = WAIT_LO;
            end
         end
         WAIT_LO: begin
            if (accept) begin
               cmd_nxt[7:0]   = rx_data;
               clr_rx_rdy_nxt = 1'b1;
               cmd_rdy_nxt    = 1'b1;
               rx_state_nxt   = HOLD;
            end else if (to_cnt == TO_LAST) begin
               to_cnt_nxt   = '0;
               rx_state_nxt = WAIT_HI;
            end else begin
               to_cnt_nxt = to_cnt + 1'b1;
            end
         end
         HOLD: begin
            // Pending bytes stay unacknowledged until the consumer releases cmd.
            if (clr_cmd_rdy) begin
               cmd_rdy_nxt  = 1'b0;
               rx_state_nxt = WAIT_HI;
            end
         end
         default: rx_state_nxt = WAIT_HI;
      endcase
   end

   // TX is the LSB of the shift register; idle fill of ones keeps the line high.
   assign TX = frame[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state  <= TX_IDLE;
         frame     <= '1;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         tx_busy   <= 1'b0;
         resp_sent <= 1'b0;
      end else begin
         tx_state  <= tx_state_nxt;
         frame     <= frame_nxt;
         baud_cnt  <= baud_cnt_nxt;
         bit_cnt   <= bit_cnt_nxt;
         tx_busy   <= tx_busy_nxt;
         resp_sent <= resp_sent_nxt;
      end
   end

   always_comb begin
      tx_state_nxt  = tx_state;
      frame_nxt     = frame;
      baud_cnt_nxt  = baud_cnt;
      bit_cnt_nxt   = bit_cnt;
      tx_busy_nxt   = tx_busy;
      resp_sent_nxt = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            if (send_resp) begin
               frame_nxt    = {1'b1, resp, 1'b0};
               baud_cnt_nxt = '0;
               bit_cnt_nxt  = '0;
               tx_busy_nxt  = 1'b1;
               tx_state_nxt = TX_SHIFT;
            end
         end
         TX_SHIFT: begin
            if (baud_cnt == BAUD_LAST) begin
               baud_cnt_nxt = '0;
               if (bit_cnt == 4'd9) begin
                  frame_nxt     = '1;
                  tx_busy_nxt   = 1'b0;
                  resp_sent_nxt = 1'b1;
                  tx_state_nxt  = TX_IDLE;
               end else begin
                  frame_nxt   = {1'b1, frame[9:1]};
                  bit_cnt_nxt = bit_cnt + 4'd1;
               end
            end else begin
               baud_cnt_nxt = baud_cnt + 1'b1;
            end
         end
         default: tx_state_nxt = TX_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Self-checking bench for uart_cmd_wrapper: randomized command bytes and
// response frames compared against a frame/pairing model kept in the bench.
`timescale 1ns/1ps

module tb_uart_cmd_wrapper;

   localparam int BAUD_DIV = 8;
   localparam int TIMEOUT  = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_rdy = 1'b0;
   logic        clr_rx_rdy;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy = 1'b0;
   logic [7:0]  resp = 8'h00;
   logic        send_resp = 1'b0;
   logic        resp_sent;
   logic        tx_busy;
   logic        TX;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q[$];

   uart_cmd_wrapper #(.BAUD_DIV(BAUD_DIV), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_rdy(rx_rdy),
      .clr_rx_rdy(clr_rx_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy),
      .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
      .resp_sent(resp_sent), .tx_busy(tx_busy), .TX(TX)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   // One clock step; also plays the UART receiver, which drops rx_rdy on the edge that sees clr_rx_rdy.
   task automatic tick();
      logic clr_before;
      clr_before = clr_rx_rdy;
      @(posedge clk);
      #1;
      if (clr_before) rx_rdy = 1'b0;
   endtask

   function automatic logic frame_bit(input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i == 9) return 1'b1;
      return b[i-1];
   endfunction

   task automatic present_byte(input logic [7:0] b);
      logic got;
      got = 1'b0;
      rx_data = b;
      rx_rdy = 1'b1;
      for (int i = 0; i < 8 && !got; i++) begin
         tick();
         if (clr_rx_rdy === 1'b1) got = 1'b1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("[TB] FAIL rx_ack byte %h: clr_rx_rdy got 0 required 1 within 8 cycles", b);
         rx_rdy = 1'b0;
      end else begin
         tick();
         checks++;
         if (clr_rx_rdy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rx_ack_pulse byte %h: clr_rx_rdy got %b required 0", b, clr_rx_rdy);
         end
      end
   endtask

   task automatic release_cmd();
      clr_cmd_rdy = 1'b1;
      tick();
      clr_cmd_rdy = 1'b0;
   endtask

   // mode 0: plain frame, 1: send_resp pulsed mid-frame, 2: send_resp on the final bit cycle
   task automatic send_and_check(input logic [7:0] b, input int mode);
      resp = b;
      send_resp = 1'b1;
      tick();
      send_resp = 1'b0;
      for (int k = 0; k < 10 * BAUD_DIV; k++) begin
         checks++;
         if (TX !== frame_bit(b, k / BAUD_DIV)) begin
            errors++;
            $display("[TB] FAIL tx_bit byte %h cycle %0d: TX got %b required %b", b, k, TX, frame_bit(b, k / BAUD_DIV));
         end
         checks++;
         if (tx_busy !== 1'b1 || resp_sent !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tx_flags byte %h cycle %0d: busy/sent got %b%b required 10", b, k, tx_busy, resp_sent);
         end
         if (mode == 1) begin
            resp = 8'h11;
            send_resp = (k >= 40 && k <= 42);
         end else if (mode == 2) begin
            resp = 8'h11;
            send_resp = (k == 10 * BAUD_DIV - 1);
         end
         tick();
      end
      send_resp = 1'b0;
      checks++;
      if (resp_sent !== 1'b1 || tx_busy !== 1'b0 || TX !== 1'b1) begin
         errors++;
         $display("[TB] FAIL tx_done byte %h: sent/busy/TX got %b%b%b required 101", b, resp_sent, tx_busy, TX);
      end
   endtask

   task automatic check_tx_idle(input int cycles, input string tag);
      for (int k = 0; k < cycles; k++) begin
         tick();
         checks++;
         if (TX !== 1'b1 || tx_busy !== 1'b0 || resp_sent !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: TX/busy/sent got %b%b%b required 100", tag, k, TX, tx_busy, resp_sent);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if (cmd !== 16'h0000 || cmd_rdy !== 1'b0 || clr_rx_rdy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_rx: cmd %h rdy %b clr %b required 0000 0 0", cmd, cmd_rdy, clr_rx_rdy);
      end
      checks++;
      if (TX !== 1'b1 || tx_busy !== 1'b0 || resp_sent !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_tx: TX/busy/sent got %b%b%b required 100", TX, tx_busy, resp_sent);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_cmd_basic();
      present_byte(8'h47);
      present_byte(8'h1A);
      for (int k = 0; k < 50; k++) begin
         checks++;
         if (cmd_rdy !== 1'b1 || cmd !== 16'h471A) begin
            errors++;
            $display("[TB] FAIL cmd_hold cycle %0d: cmd %h rdy %b required 471A 1", k, cmd, cmd_rdy);
         end
         tick();
      end
      release_cmd();
      checks++;
      if (cmd_rdy !== 1'b0 || cmd !== 16'h471A) begin
         errors++;
         $display("[TB] FAIL cmd_release: cmd %h rdy %b required 471A 0", cmd, cmd_rdy);
      end
   endtask

   task automatic test_timeout();
      present_byte(8'h80);
      for (int k = 0; k < 40; k++) begin
         tick();
         checks++;
         if (cmd_rdy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_no_rdy cycle %0d: cmd_rdy got %b required 0", k, cmd_rdy);
         end
      end
      present_byte(8'h05);
      present_byte(8'h00);
      checks++;
      if (cmd_rdy !== 1'b1 || cmd !== 16'h0500) begin
         errors++;
         $display("[TB] FAIL timeout_recover: cmd %h rdy %b required 0500 1", cmd, cmd_rdy);
      end
      release_cmd();
   endtask

   task automatic test_hold();
      present_byte(8'hA3);
      present_byte(8'h5C);
      rx_data = 8'hC1;
      rx_rdy = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         checks++;
         if (clr_rx_rdy !== 1'b0 || cmd !== 16'hA35C || cmd_rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_no_ack cycle %0d: clr %b cmd %h rdy %b required 0 A35C 1", k, clr_rx_rdy, cmd, cmd_rdy);
         end
      end
      release_cmd();
      checks++;
      if (cmd_rdy !== 1'b0 || clr_rx_rdy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL hold_release: rdy %b clr %b required 0 0", cmd_rdy, clr_rx_rdy);
      end
      tick();
      checks++;
      if (clr_rx_rdy !== 1'b1 || cmd[15:8] !== 8'hC1) begin
         errors++;
         $display("[TB] FAIL hold_pending_hi: clr %b cmd_hi %h required 1 C1", clr_rx_rdy, cmd[15:8]);
      end
      tick();
      present_byte(8'h3D);
      checks++;
      if (cmd_rdy !== 1'b1 || cmd !== 16'hC13D) begin
         errors++;
         $display("[TB] FAIL hold_next_cmd: cmd %h rdy %b required C13D 1", cmd, cmd_rdy);
      end
      release_cmd();
   endtask

   task automatic test_random_cmds();
      logic [7:0]  hi, lo;
      logic [15:0] exp;
      for (int n = 0; n < 8; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            present_byte(8'($urandom));
            repeat ($urandom_range(40, 47)) tick();
            checks++;
            if (cmd_rdy !== 1'b0) begin
               errors++;
               $display("[TB] FAIL rand_lone %0d: cmd_rdy got %b required 0", n, cmd_rdy);
            end
         end
         hi = 8'($urandom);
         lo = 8'($urandom);
         exp_q.push_back({hi, lo});
         present_byte(hi);
         repeat ($urandom_range(0, 10)) tick();
         present_byte(lo);
         exp = exp_q.pop_front();
         repeat ($urandom_range(0, 6)) begin
            checks++;
            if (cmd_rdy !== 1'b1 || cmd !== exp) begin
               errors++;
               $display("[TB] FAIL rand_cmd %0d: cmd %h rdy %b required %h 1", n, cmd, cmd_rdy, exp);
            end
            tick();
         end
         checks++;
         if (cmd_rdy !== 1'b1 || cmd !== exp) begin
            errors++;
            $display("[TB] FAIL rand_cmd_final %0d: cmd %h rdy %b required %h 1", n, cmd, cmd_rdy, exp);
         end
         release_cmd();
      end
   endtask

   task automatic test_tx();
      send_and_check(8'hA5, 0);
      check_tx_idle(5, "tx_after_a5");
   endtask

   task automatic test_mid_frame();
      send_and_check(8'hEE, 1);
      check_tx_idle(20, "tx_no_second_frame");
      send_and_check(8'h3C, 2);
      check_tx_idle(20, "tx_ignore_at_done");
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 4; n++) send_and_check(8'($urandom), 0);
      check_tx_idle(3, "tx_after_b2b");
   endtask

   task automatic test_reset_midframe();
      resp = 8'h5A;
      send_resp = 1'b1;
      tick();
      send_resp = 1'b0;
      present_byte(8'h12);
      present_byte(8'h34);
      repeat (20) tick();
      checks++;
      if (cmd_rdy !== 1'b1 || tx_busy !== 1'b1 || cmd !== 16'h1234) begin
         errors++;
         $display("[TB] FAIL prereset: cmd %h rdy %b busy %b required 1234 1 1", cmd, cmd_rdy, tx_busy);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (TX !== 1'b1 || tx_busy !== 1'b0 || resp_sent !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_reset_tx: TX/busy/sent got %b%b%b required 100", TX, tx_busy, resp_sent);
      end
      checks++;
      if (cmd !== 16'h0000 || cmd_rdy !== 1'b0 || clr_rx_rdy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_reset_rx: cmd %h rdy %b clr %b required 0000 0 0", cmd, cmd_rdy, clr_rx_rdy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      present_byte(8'h9E);
      present_byte(8'h07);
      checks++;
      if (cmd_rdy !== 1'b1 || cmd !== 16'h9E07) begin
         errors++;
         $display("[TB] FAIL post_reset_cmd: cmd %h rdy %b required 9E07 1", cmd, cmd_rdy);
      end
      release_cmd();
      send_and_check(8'h81, 0);
   endtask

   initial begin
      $display("[TB] start");
      test_reset();
      test_cmd_basic();
      test_timeout();
      test_hold();
      test_random_cmds();
      test_tx();
      test_mid_frame();
      test_back_to_back();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
